// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU issue path: opcodes, widths and
// the issue FSM state encoding.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
    localparam logic [OP_W-1:0] OP_ADD   = 3'd1;
    localparam logic [OP_W-1:0] OP_MUL   = 3'd2;
    localparam logic [OP_W-1:0] OP_SUB   = 3'd3;
    localparam logic [OP_W-1:0] OP_SHIFT = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Legal-opcode check for the ALU. Pure combinational; also used by the
// control path to pre-screen requests.
import alu_pkg::*;

module alu_op_decode (
    input  logic [OP_W-1:0] op,
    output logic            legal
);

    // Only add, mul, sub and shift reach the ALU.
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_ADD, OP_MUL, OP_SUB, OP_SHIFT: legal = 1'b1;
            default:                          legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Issue stage for the 8-bit ALU: accepts one request, drives the ALU for
// one execute phase, then holds the result until the consumer takes it.
// Optional zero flag output enabled by defining ALU_ISSUE_ZERO_EN.
//
// state | meaning
// IDLE  | ready for a request
// EXEC  | ALU driven with registered op/operands, waiting for AluValid_i
// RESP  | result held with ResValid_o until ResReady_i
import alu_pkg::*;

module alu_issue (
    input  logic              clk,
    input  logic              rstn,
    input  logic [OP_W-1:0]   Op_i,
    input  logic [DATA_W-1:0] A_i,
    input  logic [DATA_W-1:0] B_i,
    input  logic              Valid_i,
    output logic              Ready_o,
    output logic [OP_W-1:0]   Sel_o,
    output logic [DATA_W-1:0] D0_o,
    output logic [DATA_W-1:0] D1_o,
    input  logic [DATA_W-1:0] Q_i,
    input  logic              AluValid_i,
    output logic [DATA_W-1:0] Res_o,
    output logic              ResValid_o,
    input  logic              ResReady_i,
`ifdef ALU_ISSUE_ZERO_EN
    output logic              Zero_o,
`endif
    output logic              Err_o
);

    state_t            state_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic              err_q;
    logic              op_legal;
    logic              accept;

    alu_op_decode u_op_decode (
        .op    (Op_i),
        .legal (op_legal)
    );

    assign accept = (state_q == IDLE) && Valid_i;

    // Issue FSM: illegal requests skip the ALU and respond directly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (Valid_i)    state_q <= op_legal ? EXEC : RESP;
                EXEC:    if (AluValid_i) state_q <= RESP;
                RESP:    if (ResReady_i) state_q <= IDLE;
                default:                 state_q <= IDLE;
            endcase
        end
    end

    // Request capture; operands stay on D0_o/D1_o until the next accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= Op_i;
            a_q  <= A_i;
            b_q  <= B_i;
        end
    end

    // Result capture: ALU output for legal ops, zero plus error otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_q <= '0;
            err_q <= 1'b0;
        end else if (accept && !op_legal) begin
            res_q <= '0;
            err_q <= 1'b1;
        end else if ((state_q == EXEC) && AluValid_i) begin
            res_q <= Q_i;
            err_q <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_ZERO_EN
    logic zero_q;

    // Zero flag registered alongside the result it describes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            zero_q <= 1'b1;
        end else if (accept && !op_legal) begin
            zero_q <= 1'b1;
        end else if ((state_q == EXEC) && AluValid_i) begin
            zero_q <= (Q_i == '0);
        end
    end

    assign Zero_o = zero_q;
`endif

    assign Ready_o    = (state_q == IDLE);
    assign ResValid_o = (state_q == RESP);
    assign Sel_o      = (state_q == EXEC) ? op_q : '0;
    assign D0_o       = a_q;
    assign D1_o       = b_q;
    assign Res_o      = res_q;
    assign Err_o      = err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with a behavioural ALU on the far side.
`timescale 1ns/1ps

module tb_alu_issue;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] Op_i = '0;
    logic [7:0] A_i = '0;
    logic [7:0] B_i = '0;
    logic       Valid_i = 1'b0;
    logic       Ready_o;
    logic [2:0] Sel_o;
    logic [7:0] D0_o;
    logic [7:0] D1_o;
    logic [7:0] Q_i = '0;
    logic       AluValid_i = 1'b0;
    logic [7:0] Res_o;
    logic       ResValid_o;
    logic       ResReady_i = 1'b0;
    logic       Err_o;
`ifdef ALU_ISSUE_ZERO_EN
    logic       Zero_o;
`endif

    int errors = 0;
    int checks = 0;
    int alu_delay = 0;
    int exec_cnt = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk        (clk),
        .rstn       (rstn),
        .Op_i       (Op_i),
        .A_i        (A_i),
        .B_i        (B_i),
        .Valid_i    (Valid_i),
        .Ready_o    (Ready_o),
        .Sel_o      (Sel_o),
        .D0_o       (D0_o),
        .D1_o       (D1_o),
        .Q_i        (Q_i),
        .AluValid_i (AluValid_i),
        .Res_o      (Res_o),
        .ResValid_o (ResValid_o),
        .ResReady_i (ResReady_i),
`ifdef ALU_ISSUE_ZERO_EN
        .Zero_o     (Zero_o),
`endif
        .Err_o      (Err_o)
    );

    // Arithmetic the ALU performs, 8-bit wrap.
    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned r;
        case (op)
            3'd1:    r = int'(a) + int'(b);
            3'd2:    r = int'(a) * int'(b);
            3'd3:    r = int'(a) - int'(b);
            3'd4:    r = (b > 8'd7) ? 0 : (int'(a) << b);
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    function automatic bit is_legal(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    // Expected response: {err, result}.
    function automatic logic [8:0] ref_resp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        if (!is_legal(op)) return {1'b1, 8'h00};
        return {1'b0, alu_fn(op, a, b)};
    endfunction

    // Behavioural ALU: answers after alu_delay extra cycles of being selected.
    always @(negedge clk) begin
        if (Sel_o != 3'd0) begin
            Q_i        = alu_fn(Sel_o, D0_o, D1_o);
            AluValid_i = (exec_cnt >= alu_delay);
            exec_cnt   = exec_cnt + 1;
        end else begin
            exec_cnt   = 0;
            AluValid_i = 1'b0;
        end
    end

    // One request: issue, execute with given ALU latency, stall the response.
    task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int delay, input int stall);
        logic [8:0] exp;
        exp = ref_resp(op, a, b);
        @(negedge clk);
        checks++;
        if (Ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_idle op=%0d: Ready_o=%b want 1", op, Ready_o);
        end
        alu_delay  = delay;
        Op_i       = op;
        A_i        = a;
        B_i        = b;
        Valid_i    = 1'b1;
        ResReady_i = 1'b0;
        @(posedge clk);
        #1;
        Valid_i = 1'b0;
        if (is_legal(op)) begin
            for (int k = 0; k <= delay; k++) begin
                @(negedge clk);
                checks++;
                if (Sel_o !== op || Ready_o !== 1'b0 || ResValid_o !== 1'b0 || D0_o !== a || D1_o !== b) begin
                    errors++;
                    $display("FAIL exec op=%0d k=%0d: sel=%0d rdy=%b rv=%b d0=%h d1=%h want sel=%0d rdy=0 rv=0 d0=%h d1=%h",
                             op, k, Sel_o, Ready_o, ResValid_o, D0_o, D1_o, op, a, b);
                end
            end
        end
        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            checks++;
            if (ResValid_o !== 1'b1 || Ready_o !== 1'b0 || Sel_o !== 3'd0 || {Err_o, Res_o} !== exp) begin
                errors++;
                $display("FAIL resp op=%0d s=%0d: rv=%b rdy=%b sel=%0d err=%b res=%h want rv=1 rdy=0 sel=0 err=%b res=%h",
                         op, s, ResValid_o, Ready_o, Sel_o, Err_o, Res_o, exp[8], exp[7:0]);
            end
`ifdef ALU_ISSUE_ZERO_EN
            checks++;
            if (Zero_o !== (exp[7:0] == 8'h00)) begin
                errors++;
                $display("FAIL zero op=%0d: Zero_o=%b want %b", op, Zero_o, exp[7:0] == 8'h00);
            end
`endif
            if (s < stall) begin
                Valid_i = 1'b1;
                Op_i    = 3'(($urandom_range(1, 4)));
                A_i     = 8'($urandom);
            end else begin
                Valid_i    = 1'b0;
                ResReady_i = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        ResReady_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ResValid_o !== 1'b0 || Ready_o !== 1'b1) begin
            errors++;
            $display("FAIL retire op=%0d: rv=%b rdy=%b want rv=0 rdy=1", op, ResValid_o, Ready_o);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        checks++;
        if (Ready_o !== 1'b1 || Sel_o !== 3'd0 || D0_o !== 8'h00 || D1_o !== 8'h00 ||
            Res_o !== 8'h00 || ResValid_o !== 1'b0 || Err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b sel=%0d d0=%h d1=%h res=%h rv=%b err=%b want 1 0 00 00 00 0 0",
                     Ready_o, Sel_o, D0_o, D1_o, Res_o, ResValid_o, Err_o);
        end
`ifdef ALU_ISSUE_ZERO_EN
        checks++;
        if (Zero_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_zero: Zero_o=%b want 1", Zero_o);
        end
`endif
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_add();
        do_op(3'd1, 8'h0F, 8'h01, 0, 0);
    endtask

    task automatic test_sub_wrap();
        do_op(3'd3, 8'h05, 8'h06, 0, 1);
    endtask

    task automatic test_illegal();
        do_op(3'd6, 8'h12, 8'h34, 0, 0);
        do_op(3'd0, 8'hAA, 8'h55, 0, 0);
    endtask

    task automatic test_stall();
        do_op(3'd2, 8'h10, 8'h10, 0, 5);
        do_op(3'd4, 8'h03, 8'h02, 2, 2);
    endtask

    task automatic test_reset_mid_exec();
        @(negedge clk);
        alu_delay = 4;
        Op_i      = 3'd1;
        A_i       = 8'h21;
        B_i       = 8'h22;
        Valid_i   = 1'b1;
        @(posedge clk);
        #1;
        Valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (Sel_o !== 3'd1) begin
            errors++;
            $display("FAIL mid_exec_entry: Sel_o=%0d want 1", Sel_o);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (Ready_o !== 1'b1 || ResValid_o !== 1'b0 || Sel_o !== 3'd0) begin
            errors++;
            $display("FAIL mid_exec_reset: rdy=%b rv=%b sel=%0d want 1 0 0", Ready_o, ResValid_o, Sel_o);
        end
        #2;
        rstn = 1'b1;
        ResReady_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (ResValid_o !== 1'b0 || Sel_o !== 3'd0) begin
                errors++;
                $display("FAIL aborted_resp cyc=%0d: rv=%b sel=%0d want 0 0", i, ResValid_o, Sel_o);
            end
        end
        ResReady_i = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        for (int n = 0; n < 25; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = 8'($urandom);
            do_op(op, a, b, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [4];
        logic [7:0] as  [4];
        logic [7:0] bs  [4];
        logic [8:0] q[$];
        logic [8:0] exp;
        int idx = 0;
        int last_acc = -1;
        int popped = 0;
        for (int i = 0; i < 4; i++) begin
            ops[i] = 3'($urandom_range(1, 4));
            as[i]  = 8'($urandom);
            bs[i]  = 8'($urandom);
        end
        @(negedge clk);
        alu_delay  = 0;
        ResReady_i = 1'b1;
        Valid_i    = 1'b1;
        Op_i = ops[0]; A_i = as[0]; B_i = bs[0];
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (ResValid_o === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: res=%h with no outstanding op", Res_o);
                end else begin
                    exp = q.pop_front();
                    popped++;
                    if ({Err_o, Res_o} !== exp) begin
                        errors++;
                        $display("FAIL b2b_order n=%0d: err=%b res=%h want err=%b res=%h",
                                 popped, Err_o, Res_o, exp[8], exp[7:0]);
                    end
                end
            end
            if (Ready_o === 1'b1 && Valid_i) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 3) begin
                        errors++;
                        $display("FAIL b2b_spacing: gap=%0d want 3", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                q.push_back(ref_resp(ops[idx], as[idx], bs[idx]));
                idx++;
                @(posedge clk);
                #1;
                if (idx < 4) begin
                    Op_i = ops[idx]; A_i = as[idx]; B_i = bs[idx];
                end else begin
                    Valid_i = 1'b0;
                end
            end
        end
        ResReady_i = 1'b0;
        Valid_i    = 1'b0;
        checks++;
        if (popped != 4 || idx != 4) begin
            errors++;
            $display("FAIL b2b_count: accepted=%0d results=%0d want 4 4", idx, popped);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_wrap();
        test_illegal();
        test_stall();
        test_reset_mid_exec();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
